// File: rtl/mig_app_model.sv
// Purpose : RAM-backed stand-in for the MIG app_* responder (commands, write data, read return).
// Latency : reads return RD_LAT cycles after accept; writes commit one per cycle once cmd and data pair up.
// Backpressure: app_rdy/app_wdf_rdy drop on a full FIFO, before calibration, and app_rdy also drops for reads
//   while writes are pending; read data cannot be stalled.
// Ports: ui_clk/rst_n clock and async active-low reset; init_calib_complete model ready;
//   app_addr/app_cmd/app_en/app_rdy command channel; app_wdf_* write-data channel;
//   app_rd_data* read return; app_ref/zq req/ack handshakes; app_sr_* self-refresh (ignored);
//   proto_err sticky protocol-error flag.
module mig_app_model #(
  parameter int MEM_AW      = 10,
  parameter int RD_LAT      = 4,
  parameter int INIT_CYCLES = 100,
  parameter int FIFO_AW     = 2
) (
  input  logic         ui_clk,
  input  logic         rst_n,
  output logic         init_calib_complete,
  input  logic [27:0]  app_addr,
  input  logic [2:0]   app_cmd,
  input  logic         app_en,
  output logic         app_rdy,
  input  logic [127:0] app_wdf_data,
  input  logic [15:0]  app_wdf_mask,
  input  logic         app_wdf_wren,
  input  logic         app_wdf_end,
  output logic         app_wdf_rdy,
  output logic [127:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end,
  input  logic         app_ref_req,
  output logic         app_ref_ack,
  input  logic         app_zq_req,
  output logic         app_zq_ack,
  input  logic         app_sr_req,
  output logic         app_sr_active,
  output logic         proto_err
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int FD    = 1 << FIFO_AW;
  // Counter only has to reach INIT_CYCLES-1; the done flag holds the final state.
  localparam int CW    = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);

  // ---------------- calibration delay ----------------
  logic [CW-1:0] init_cnt;
  logic          init_done;

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == CW'(INIT_CYCLES - 1)) init_done <= 1'b1;
    end
  end

  assign init_calib_complete = init_done;

  // ---------------- command decode ----------------
  logic              is_wr, is_rd;
  logic              wcmd_empty, wcmd_full, wdata_empty, wdata_full;
  logic              cmd_acc, wcmd_push, rd_acc, bad_cmd, wdata_push, commit;
  logic [MEM_AW-1:0] cmd_idx;

  assign is_wr   = (app_cmd == 3'b000);
  assign is_rd   = (app_cmd == 3'b001);
  assign cmd_idx = app_addr[MEM_AW+2:3];

  // A read waits until every earlier write command has committed, which keeps read-after-write order.
  assign app_rdy     = init_done & ~wcmd_full & ~(is_rd & ~wcmd_empty);
  assign app_wdf_rdy = init_done & ~wdata_full;

  assign cmd_acc    = app_en & app_rdy;
  assign wcmd_push  = cmd_acc & is_wr;
  assign rd_acc     = cmd_acc & is_rd;
  assign bad_cmd    = cmd_acc & ~is_wr & ~is_rd;
  assign wdata_push = app_wdf_wren & app_wdf_rdy;
  assign commit     = ~wcmd_empty & ~wdata_empty;

  // ---------------- write command / write data FIFOs ----------------
  logic [MEM_AW-1:0]  wcmd_mem  [FD];
  logic [143:0]       wdata_mem [FD];
  logic [FIFO_AW:0]   wcmd_wp, wcmd_rp, wdata_wp, wdata_rp;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign wcmd_empty  = (wcmd_wp == wcmd_rp);
  assign wcmd_full   = (wcmd_wp[FIFO_AW] != wcmd_rp[FIFO_AW]) &&
                       (wcmd_wp[FIFO_AW-1:0] == wcmd_rp[FIFO_AW-1:0]);
  assign wdata_empty = (wdata_wp == wdata_rp);
  assign wdata_full  = (wdata_wp[FIFO_AW] != wdata_rp[FIFO_AW]) &&
                       (wdata_wp[FIFO_AW-1:0] == wdata_rp[FIFO_AW-1:0]);

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      wcmd_wp  <= '0;
      wcmd_rp  <= '0;
      wdata_wp <= '0;
      wdata_rp <= '0;
    end else begin
      if (wcmd_push)  wcmd_wp  <= wcmd_wp + 1'b1;
      if (wdata_push) wdata_wp <= wdata_wp + 1'b1;
      if (commit) begin
        wcmd_rp  <= wcmd_rp + 1'b1;
        wdata_rp <= wdata_rp + 1'b1;
      end
    end
  end

  always_ff @(posedge ui_clk) begin
    if (wcmd_push)  wcmd_mem[wcmd_wp[FIFO_AW-1:0]]   <= cmd_idx;
    if (wdata_push) wdata_mem[wdata_wp[FIFO_AW-1:0]] <= {app_wdf_mask, app_wdf_data};
  end

  // ---------------- backing RAM ----------------
  logic [127:0]      mem [DEPTH];
  logic [MEM_AW-1:0] cm_idx;
  logic [143:0]      cm_ent;

  assign cm_idx = wcmd_mem[wcmd_rp[FIFO_AW-1:0]];
  assign cm_ent = wdata_mem[wdata_rp[FIFO_AW-1:0]];

  // Mask bit 1 means the byte keeps its old value.
  always_ff @(posedge ui_clk) begin
    if (commit) begin
      for (int b = 0; b < 16; b++) begin
        if (!cm_ent[128+b]) mem[cm_idx][b*8 +: 8] <= cm_ent[b*8 +: 8];
      end
    end
  end

  // ---------------- read pipeline ----------------
  // RD_LAT-1 delay stages plus the output register give exactly RD_LAT cycles.
  logic              rd_vld [RD_LAT-1];
  logic [MEM_AW-1:0] rd_idx [RD_LAT-1];

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT-1; i++) rd_vld[i] <= 1'b0;
      app_rd_data_valid <= 1'b0;
      app_rd_data       <= '0;
    end else begin
      rd_vld[0] <= rd_acc;
      for (int i = 1; i < RD_LAT-1; i++) rd_vld[i] <= rd_vld[i-1];
      app_rd_data_valid <= rd_vld[RD_LAT-2];
      app_rd_data       <= mem[rd_idx[RD_LAT-2]];
    end
  end

  always_ff @(posedge ui_clk) begin
    rd_idx[0] <= cmd_idx;
    for (int i = 1; i < RD_LAT-1; i++) rd_idx[i] <= rd_idx[i-1];
  end

  assign app_rd_data_end = app_rd_data_valid;

  // ---------------- maintenance handshakes and error flag ----------------
  logic ref_pend, zq_pend;

  // A request seen while an ack is already pending folds into that ack.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_pend    <= 1'b0;
      zq_pend     <= 1'b0;
      app_ref_ack <= 1'b0;
      app_zq_ack  <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      ref_pend    <= app_ref_req & ~ref_pend;
      zq_pend     <= app_zq_req & ~zq_pend;
      app_ref_ack <= ref_pend;
      app_zq_ack  <= zq_pend;
      if (bad_cmd || (app_wdf_wren != app_wdf_end)) proto_err <= 1'b1;
    end
  end

  assign app_sr_active = 1'b0;

  // Self-refresh request and address bits outside the RAM index have no effect.
  logic unused_bits;
  assign unused_bits = ^{app_sr_req, app_addr[27:MEM_AW+3], app_addr[2:0]};

endmodule
